// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer_pkg
//  Description : Shared width, state encoding, divide-by-zero constant and
//                two's-complement negation helper for the divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package div_sequencer_pkg;

    localparam int WIDTH = 32;

    // Explicit 3-bit encoding keeps the state register width fixed.
    typedef enum logic [2:0] {
        DS_IDLE  = 3'd0,
        DS_START = 3'd1,
        DS_WAIT  = 3'd2,
        DS_FIX   = 3'd3,
        DS_DONE  = 3'd4
    } div_seq_state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    // Modulo-2^WIDTH negation, so the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return '0 - x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer_sign_mag.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer_sign_mag
//  Description : Combinational magnitude/sign extraction of one operand.
//                Unsigned operands pass through with a clear sign bit.
//  Revision    : 1.0  initial release
// ============================================================================
module div_sequencer_sign_mag
    import div_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    // Negate only signed negative values; 0x80000000 stays 0x80000000.
    always_comb begin
        sign      = is_signed & value[WIDTH-1];
        magnitude = sign ? negate(value) : value;
    end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer
//  Description : Handshaked control stage in front of the 32-bit iterative
//                divider: operand magnitudes out, sign-corrected quotient (LO)
//                and remainder (HI) back. Zero divisors and divisors with the
//                top bit set are resolved locally without starting the divider.
//  Revision    : 1.0  initial release
// ============================================================================
module div_sequencer
    import div_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_finished
);

    div_seq_state_t   state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bypass_q, bypass_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_lo_q, out_lo_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_a, sign_b;
    logic             a_ge_b;

    div_sequencer_sign_mag u_sign_a (
        .value     (in_dividend),
        .is_signed (in_signed),
        .magnitude (mag_a),
        .sign      (sign_a)
    );

    div_sequencer_sign_mag u_sign_b (
        .value     (in_divisor),
        .is_signed (in_signed),
        .magnitude (mag_b),
        .sign      (sign_b)
    );

    assign a_ge_b = (mag_a >= mag_b);

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d  = state_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        bypass_d = bypass_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;

        case (state_q)
            DS_IDLE: begin
                if (in_valid) begin
                    mag_a_d   = mag_a;
                    mag_b_d   = mag_b;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    bypass_d  = 1'b0;
                    if (in_divisor == '0) begin
                        quo_d    = DIV0_QUOTIENT;
                        rem_d    = in_dividend;
                        bypass_d = 1'b1;
                        state_d  = DS_FIX;
                    end else if (mag_b[WIDTH-1]) begin
                        // The divider sign-extends its divisor, so a quotient
                        // of 0 or 1 is resolved here instead.
                        quo_d   = {{(WIDTH-1){1'b0}}, a_ge_b};
                        rem_d   = a_ge_b ? (mag_a - mag_b) : mag_a;
                        state_d = DS_FIX;
                    end else begin
                        state_d = DS_START;
                    end
                end
            end
            DS_START: begin
                state_d = DS_WAIT;
            end
            DS_WAIT: begin
                if (div_finished) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    state_d = DS_FIX;
                end
            end
            DS_FIX: begin
                out_lo_d = (neg_quo_q && !bypass_q) ? negate(quo_q) : quo_q;
                out_hi_d = (neg_rem_q && !bypass_q) ? negate(rem_q) : rem_q;
                state_d  = DS_DONE;
            end
            DS_DONE: begin
                if (out_ready) begin
                    state_d = DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase

        in_ready_d  = (state_d == DS_IDLE);
        out_valid_d = (state_d == DS_DONE);
        div_start_d = (state_d == DS_START);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DS_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            bypass_q    <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            div_start_q <= div_start_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            bypass_q    <= bypass_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign div_start    = div_start_q;
    assign div_dividend = mag_a_q;
    assign div_divisor  = mag_b_q;
    assign out_lo       = out_lo_q;
    assign out_hi       = out_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_sequencer
//  Description : Directed testbench for div_sequencer with a behavioural
//                33-cycle iterative divider model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_lo;
    logic [31:0] out_hi;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_finished;

    int checks = 0;
    int errors = 0;

    div_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lo        (out_lo),
        .out_hi        (out_hi),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_finished  (div_finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider model: unsigned divide of magnitudes, finished becomes visible
    // 33 clocks after the start pulse falls; start clears finished at once.
    logic       fin_r;
    logic       busy_r;
    logic [5:0] cnt_r;
    initial begin
        fin_r = 1'b0; busy_r = 1'b0; cnt_r = '0;
        div_quotient = '0; div_remainder = '0;
    end
    always @(posedge clock) begin
        if (div_start) begin
            busy_r        <= 1'b1;
            cnt_r         <= '0;
            fin_r         <= 1'b0;
            div_quotient  <= (div_divisor != 0) ? div_dividend / div_divisor : 32'h0;
            div_remainder <= (div_divisor != 0) ? div_dividend % div_divisor : 32'h0;
        end else if (busy_r) begin
            if (cnt_r == 6'd31) begin
                fin_r  <= 1'b1;
                busy_r <= 1'b0;
            end
            cnt_r <= cnt_r + 6'd1;
        end
    end
    assign div_finished = fin_r & ~div_start;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat,
                         input int exp_starts, input int hold);
        int cyc;
        int starts;
        @(negedge clock);
        check_val({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        cyc    = 1;
        starts = div_start ? 1 : 0;
        check_val({tag, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
        while (!out_valid && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (div_start) starts++;
        end
        check_val({tag, "_latency"}, cyc, exp_lat);
        check_val({tag, "_starts"}, starts, exp_starts);
        check_val({tag, "_lo"}, out_lo, exp_lo);
        check_val({tag, "_hi"}, out_hi, exp_hi);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check_val({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check_val({tag, "_hold_lo"}, out_lo, exp_lo);
            check_val({tag, "_hold_hi"}, out_hi, exp_hi);
            check_val({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check_val({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check_val({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check_val({tag, "_div_start"}, {31'b0, div_start}, 32'd0);
        check_val({tag, "_out_lo"}, out_lo, 32'd0);
        check_val({tag, "_out_hi"}, out_hi, 32'd0);
        check_val({tag, "_div_dividend"}, div_dividend, 32'd0);
        check_val({tag, "_div_divisor"}, div_divisor, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("rst");
        @(negedge clock);
        reset_n = 1'b1;

        do_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          36, 1, 0);
        do_op("s-100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  36, 1, 0);
        do_op("s100_-7",  1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          36, 1, 0);
        do_op("s_div0",   1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  2,  0, 0);
        do_op("u_div0",   1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  2,  0, 0);
        do_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          36, 1, 0);
        do_op("u_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  2,  0, 0);
        do_op("s5_min",   1'b1, 32'd5,          32'h8000_0000,  32'd0,          32'd5,          2,  0, 0);

        // Reset in the middle of a divider wait.
        @(negedge clock);
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'd100;
        in_divisor  = 32'd7;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        check_reset_state("rst_wait");
        @(negedge clock);
        reset_n = 1'b1;

        do_op("u9_2_bp",  1'b0, 32'd9,          32'd2,          32'd4,          32'd1,          36, 1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Control stage between the ALU issue logic and the 32-bit iterative divider. Accepts one signed or unsigned DIV request through a valid/ready handshake and drives the divider with operand magnitudes. It waits for the divider's `finished`, applies sign correction, and presents quotient (LO) and remainder (HI) through a second valid/ready handshake. Divide-by-zero and divisors with bit 31 set are resolved locally without starting the divider.

## Interface
- `WIDTH`, 32: operand/result width; the divider port widths match it.
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  sequencer can accept; high only in IDLE
- `in_signed`  in  1  1 = signed divide, 0 = unsigned
- `in_dividend`, `in_divisor`  in  WIDTH  operands
- `out_valid`  out  1  result present; held until accepted
- `out_ready`  in  1  consumer accepts result
- `out_lo`  out  WIDTH  quotient
- `out_hi`  out  WIDTH  remainder
- `div_start`  out  1  one-cycle start pulse to divider
- `div_dividend`, `div_divisor`  out  WIDTH  magnitudes to divider, stable from START until exit from WAIT
- `div_quotient`, `div_remainder`  in  WIDTH  divider results
- `div_finished`  in  1  divider done; level, cleared by `div_start`

## Operation
- States: IDLE, START, WAIT, FIX, DONE.
- IDLE: when `in_valid & in_ready`, latch operands, `in_signed`, `neg_q = signed & (a[31]^b[31])` and `neg_r = signed & a[31]`.
  - Magnitudes: `|x| = signed & x[31] ? -x : x`, computed modulo 2^32, so `|0x80000000| = 0x80000000`.
- Next-state decision in IDLE:
  - divisor == 0: go to FIX with q = 0xFFFFFFFF and r = dividend (raw, no sign fix).
  - `|divisor|[31]` == 1: go to FIX with q = (|a| >= |b|) ? 1 : 0 and r = |a| - q·|b|. The divider sign-extends the divisor, so this case must never reach it.
  - Otherwise: go to START.
- START: `div_start` = 1 for exactly one cycle; go to WAIT.
- WAIT: stay until `div_finished` = 1 is sampled; then capture `div_quotient` and `div_remainder`; go to FIX.
- FIX: apply `out_lo = neg_q ? -q : q` and `out_hi = neg_r ? -r : r`. Divide-by-zero results bypass the negation. Go to DONE.
- DONE: `out_valid` = 1. On `out_ready` go to IDLE.
- Overflow case: -2^31 / -1 gives q = 0x80000000, r = 0 naturally; no special path.
- Reset (any state, including mid-WAIT):
  - State returns to IDLE.
  - `in_ready` = 1; `out_valid`, `div_start` = 0.
  - `out_lo`, `out_hi`, `div_dividend`, `div_divisor` = 0.
  - The divider may still be running; its `finished` is ignored until the next START re-clears it.

## Timing
- All outputs are registered.
- `in_ready` deasserts the cycle after acceptance.
- Divider path:
  - `div_start` is high in the cycle after acceptance.
  - WAIT lasts the divider latency: 33 clocks after `div_start` falls.
  - FIX takes 1 cycle; `out_valid` rises the following cycle.
  - Total acceptance-to-`out_valid` = 36 cycles with the current divider.
- Local paths (zero divisor or divisor bit 31 set): `out_valid` rises 2 cycles after acceptance.
- `div_finished` is not sampled in START. A stale high `finished` from a prior operation must never end WAIT early; the start pulse clears it asynchronously before the first WAIT sample.
- `out_lo`/`out_hi` are stable while `out_valid` = 1 and `out_ready` = 0.
- No new request is accepted in the cycle DONE exits; IDLE is entered first, so the minimum spacing is 1 idle cycle.

## Structure
- Shared package contents:
  - `WIDTH`
  - state enum `div_seq_state_t` {IDLE, START, WAIT, FIX, DONE}
  - constant `DIV0_QUOTIENT = 32'hFFFF_FFFF`
- One combinational sub-module is natural: `sign_mag` (input value plus signed flag → magnitude and sign bit). Instantiate it twice for the operands; the same negation function is reused in FIX.
- The divider is not instantiated here; the datapath top connects the `div_*` ports.

## Test plan
- Unsigned 100 / 7 → `out_lo` = 14, `out_hi` = 2. `div_start` pulses once; `out_valid` 36 cycles after acceptance.
- Signed -100 / 7 → `out_lo` = 0xFFFFFFF2, `out_hi` = 0xFFFFFFFE. Signed 100 / -7 → `out_lo` = 0xFFFFFFF2, `out_hi` = 2.
- Divide-by-zero 0x12345678 / 0 (signed and unsigned) → `out_lo` = 0xFFFFFFFF, `out_hi` = 0x12345678. `div_start` never asserted; `out_valid` 2 cycles after acceptance.
- Signed 0x80000000 / 0xFFFFFFFF → `out_lo` = 0x80000000, `out_hi` = 0.
- Unsigned 0xFFFFFFFF / 0x80000000 → `out_lo` = 1, `out_hi` = 0x7FFFFFFF via the local path. Signed 5 / 0x80000000 → `out_lo` = 0, `out_hi` = 5 via the local path.
- Reset and backpressure:
  - Assert `reset_n` = 0 mid-WAIT → all outputs at reset values and `in_ready` = 1.
  - A following 9 / 2 request → `out_lo` = 4, `out_hi` = 1.
  - Hold `out_ready` = 0 for 10 cycles → `out_valid` and results stable, `in_ready` = 0 throughout.
